alu_md: RTL and testbench
=========================

# alu_md

Parametrised, handshaked execute unit for the RISC-V core: RV32I/RV64I integer ALU, branch comparator and the M extension (MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU). It sits between the decode/operand-fetch stage and writeback. Base ops and multiplies have a fixed 1-cycle latency. Divides and remainders use an iterative restoring divider.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32 or 64.
- SHAMT_W, $clog2(XLEN): shift-amount width. Derived; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- op_class  in  2  op_class_t: OPC_ALU, OPC_BRANCH, OPC_ADDR (load/store address), OPC_MD (M extension)
- funct3  in  3  instruction funct3
- funct7_5  in  1  instruction bit 30; selects SUB and SRA
- imm_op  in  1  1 = I-type; forces add for funct3 000 and ignores funct7_5 except for SRAI
- alu_in1, alu_in2  in  XLEN  operands
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- alu_result  out  XLEN  result
- predicate  out  1  branch taken; 0 for non-branch ops

## Operation
- Handshake: a request is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready) && !rst. Issue in the same cycle as a consume is allowed.
- While out_valid && !out_ready, alu_result and predicate hold stable.
- States are IDLE, DIV and DONE.
  - IDLE: non-MD, MUL* and special-case DIV requests go to IDLE and set out_valid on the next edge. A normal DIV/REM request goes to DIV.
  - DIV: runs XLEN iterations, then goes to DONE.
  - DONE: sets out_valid and returns to IDLE.
- OPC_ALU follows the standard RV funct3 map.
  - SRA/SRAI is an arithmetic shift of $signed(in1).
  - Shifts use in2[SHAMT_W-1:0] only.
  - SLT/SLTU write zero-extended 0/1.
- OPC_BRANCH: the funct3 map is BEQ, BNE, BLT, BGE, BLTU, BGEU. alu_result = in1 - in2. funct3 010/011 gives predicate 0.
- OPC_ADDR: alu_result = in1 + in2, predicate 0.
- OPC_MD MUL ops: MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits of the 2·XLEN product with signed×signed, signed×unsigned and unsigned×unsigned operands.
- OPC_MD DIV ops:
  - Signed ops divide magnitudes and fix signs at the end. The remainder takes the dividend's sign.
  - Divide by zero: quotient = all ones, remainder = in1. Takes the 1-cycle path.
  - Signed overflow (in1 = most-negative, in2 = −1): quotient = in1, remainder = 0. Takes the 1-cycle path.
- Arithmetic wraps modulo 2^XLEN. There is no overflow flag.
- Reset: state = IDLE, out_valid = 0, alu_result = 0, predicate = 0, divider registers = 0. Reset during DIV aborts the operation and produces no output.

## Timing
- Non-divide ops: accepted at edge t, out_valid is high after edge t+1. Back-to-back throughput is 1 per cycle when out_ready = 1.
- Normal divide: out_valid is high after edge t+XLEN+2, i.e. 34 cycles for XLEN = 32. in_ready stays 0 for the whole divide.
- Divide special cases: 1-cycle latency.
- The result register is loaded only on result completion. It never changes while stalled.

## Structure
- Put these in the shared types package: op_class_t, the FUNCT3_* constants (ALU, branch and M sets), and state_t.
- One sub-module: div_iter. It is a radix-2 restoring divider with start/done, unsigned XLEN-bit operands, and quotient and remainder outputs. Sign handling stays in alu_md.
- The multiplier is a behavioural combinational `*` on XLEN+1-bit sign-extended operands.

## Test plan
- ADD then SUB (in1=5, in2=7, funct7_5=0/1) -> 12, then 0xFFFFFFFE. Each is valid 1 cycle after accept, back-to-back with out_ready=1.
- SRA in1=0x80000000, in2=0x24 -> shamt 4, result 0xF8000000. SRL of the same operands -> 0x08000000.
- BLT in1=0xFFFFFFFF, in2=1 -> predicate 1. BLTU with the same operands -> predicate 0. BEQ 3,3 -> predicate 1.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU of the same operands -> 0x40000000. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV −7/2 -> −3. REM −7/2 -> −1, with latency 34 and in_ready 0 throughout. DIV x/0 -> 0xFFFFFFFF. DIV 0x80000000/−1 -> 0x80000000. Both special cases have 1-cycle latency.
- Hold out_ready=0 for 5 cycles after a result: output is stable and in_ready=0. Assert rst mid-divide: out_valid stays 0 and in_ready rises after rst falls.

Source files
------------

// File: rtl/alu_md_pkg.sv
// Shared types for the alu_md execute unit.
// Contents: op_class_t (request class), funct3 encodings for the integer ALU,
// branch comparator and M extension, and state_t for the control FSM.
package alu_md_pkg;

  typedef enum logic [1:0] {
    OPC_ALU    = 2'd0,
    OPC_BRANCH = 2'd1,
    OPC_ADDR   = 2'd2,
    OPC_MD     = 2'd3
  } op_class_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

endpackage

// File: rtl/alu_md_div_iter.sv
// Radix-2 restoring divider on unsigned XLEN-bit operands.
// Ports: clk, rst (sync, active-high), start (load operands and do the first
// iteration), dividend, divisor, quotient, remainder, done (one-cycle pulse
// once quotient/remainder hold the final values; they stay put until the
// next start).
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] dvsr;
  logic [CW-1:0]   cnt;
  logic            busy;

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  function automatic logic [2*XLEN-1:0] step(input logic [XLEN-1:0] r,
                                             input logic [XLEN-1:0] q,
                                             input logic [XLEN-1:0] d);
    logic [XLEN:0] sh;
    logic [XLEN:0] df;
    sh = {r, q[XLEN-1]};
    df = sh - {1'b0, d};
    if (!df[XLEN]) step = {df[XLEN-1:0], q[XLEN-2:0], 1'b1};
    else           step = {sh[XLEN-1:0], q[XLEN-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      remainder <= '0;
      quotient  <= '0;
      dvsr      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        {remainder, quotient} <= step('0, dividend, divisor);
        dvsr <= divisor;
        cnt  <= CW'(XLEN - 1);
        busy <= 1'b1;
      end else if (busy) begin
        {remainder, quotient} <= step(remainder, quotient, dvsr);
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_md.sv
// Handshaked RV32I/RV64I execute unit: integer ALU, branch comparator,
// address adder and M extension (single-cycle multiply, iterative divide).
// Ports: clk, rst (sync, active-high); request side in_valid/in_ready with
// op_class, funct3, funct7_5, imm_op, alu_in1, alu_in2; result side
// out_valid/out_ready with alu_result and predicate (branch taken).
module alu_md
  import alu_md_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op_class,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            imm_op,
  input  logic [XLEN-1:0] alu_in1,
  input  logic [XLEN-1:0] alu_in2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            predicate
);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t    state;
  op_class_t opc;
  logic      fire;

  logic [SHAMT_W-1:0]      shamt;
  logic [XLEN-1:0]         sum, diff;
  logic                    lt_s, lt_u, eq;
  logic [XLEN-1:0]         res_p0;
  logic                    pred_p0;
  logic signed [XLEN:0]    mul_a, mul_b;
  logic signed [2*XLEN-1:0] prod;
  logic                    div_signed, div_zero, div_ovf, need_div;
  logic [XLEN-1:0]         dvd_mag, dvs_mag;

  logic                    rem_p1, neg_q_p1, neg_r_p1;
  logic [XLEN-1:0]         div_quo, div_rem;
  logic                    div_done;

  function automatic logic [XLEN-1:0] negate_if(input logic neg,
                                                input logic [XLEN-1:0] v);
    negate_if = neg ? (~v + XLEN'(1)) : v;
  endfunction

  assign opc      = op_class_t'(op_class);
  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !rst;
  assign fire     = in_valid && in_ready;

  assign shamt = alu_in2[SHAMT_W-1:0];
  assign sum   = alu_in1 + alu_in2;
  assign diff  = alu_in1 - alu_in2;
  assign lt_s  = $signed(alu_in1) < $signed(alu_in2);
  assign lt_u  = alu_in1 < alu_in2;
  assign eq    = alu_in1 == alu_in2;

  // Operand sign extension selects MULH / MULHSU / MULHU behaviour.
  assign mul_a = {(funct3 != FUNCT3_MULHU) & alu_in1[XLEN-1], alu_in1};
  assign mul_b = {((funct3 == FUNCT3_MUL) || (funct3 == FUNCT3_MULH)) & alu_in2[XLEN-1],
                  alu_in2};
  assign prod  = (2*XLEN)'(mul_a) * (2*XLEN)'(mul_b);

  assign div_signed = !funct3[0];
  assign div_zero   = alu_in2 == '0;
  assign div_ovf    = div_signed && (alu_in1 == MOST_NEG) && (alu_in2 == '1);
  assign need_div   = (opc == OPC_MD) && funct3[2] && !div_zero && !div_ovf;
  assign dvd_mag    = negate_if(div_signed & alu_in1[XLEN-1], alu_in1);
  assign dvs_mag    = negate_if(div_signed & alu_in2[XLEN-1], alu_in2);

  always_comb begin
    res_p0  = '0;
    pred_p0 = 1'b0;
    unique case (opc)
      OPC_ALU: begin
        unique case (funct3)
          FUNCT3_ADD:  res_p0 = (funct7_5 && !imm_op) ? diff : sum;
          FUNCT3_SLL:  res_p0 = alu_in1 << shamt;
          FUNCT3_SLT:  res_p0 = {{(XLEN-1){1'b0}}, lt_s};
          FUNCT3_SLTU: res_p0 = {{(XLEN-1){1'b0}}, lt_u};
          FUNCT3_XOR:  res_p0 = alu_in1 ^ alu_in2;
          FUNCT3_SR:   res_p0 = funct7_5 ? XLEN'($signed(alu_in1) >>> shamt)
                                         : alu_in1 >> shamt;
          FUNCT3_OR:   res_p0 = alu_in1 | alu_in2;
          default:     res_p0 = alu_in1 & alu_in2;
        endcase
      end
      OPC_BRANCH: begin
        res_p0 = diff;
        unique case (funct3)
          FUNCT3_BEQ:  pred_p0 = eq;
          FUNCT3_BNE:  pred_p0 = !eq;
          FUNCT3_BLT:  pred_p0 = lt_s;
          FUNCT3_BGE:  pred_p0 = !lt_s;
          FUNCT3_BLTU: pred_p0 = lt_u;
          FUNCT3_BGEU: pred_p0 = !lt_u;
          default:     pred_p0 = 1'b0;
        endcase
      end
      OPC_ADDR: res_p0 = sum;
      default: begin
        if (!funct3[2])
          res_p0 = (funct3 == FUNCT3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (div_zero)
          res_p0 = funct3[1] ? alu_in1 : '1;
        else
          res_p0 = funct3[1] ? '0 : alu_in1;
      end
    endcase
  end

  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (fire && need_div),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Stage p1: sign fix-up flags captured at divide issue.
  always_ff @(posedge clk) begin
    if (fire && need_div) begin
      rem_p1   <= funct3[1];
      neg_q_p1 <= div_signed & (alu_in1[XLEN-1] ^ alu_in2[XLEN-1]);
      neg_r_p1 <= div_signed & alu_in1[XLEN-1];
    end
  end

  // Result register and control FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      alu_result <= '0;
      predicate  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fire) begin
            if (need_div) begin
              state <= DIV;
            end else begin
              out_valid  <= 1'b1;
              alu_result <= res_p0;
              predicate  <= pred_p0;
            end
          end
        end
        DIV: begin
          if (div_done) state <= DONE;
        end
        default: begin
          state      <= IDLE;
          out_valid  <= 1'b1;
          predicate  <= 1'b0;
          alu_result <= rem_p1 ? negate_if(neg_r_p1, div_rem)
                               : negate_if(neg_q_p1, div_quo);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md (XLEN = 32): directed vector table plus
// hand-written sequences for back-to-back issue, output stall and reset
// during a divide.
module tb_alu_md;
  import alu_md_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op_class = 2'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7_5 = 1'b0;
  logic        imm_op = 1'b0;
  logic [31:0] alu_in1 = '0;
  logic [31:0] alu_in2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_result;
  logic        predicate;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_md #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_class   (op_class),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .imm_op     (imm_op),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .predicate  (predicate)
  );

  typedef struct {
    string       name;
    logic [1:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic        imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        pred;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [1:0] opc, logic [2:0] f3,
                              logic f7, logic imm, logic [31:0] a, logic [31:0] b,
                              logic [31:0] res, logic pred, int lat);
    vec_t v;
    v.name = name; v.opc = opc; v.f3 = f3; v.f7 = f7; v.imm = imm;
    v.a = a; v.b = b; v.res = res; v.pred = pred; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] opc, input logic [2:0] f3, input logic f7,
                       input logic imm, input logic [31:0] a, input logic [31:0] b);
    op_class = opc; funct3 = f3; funct7_5 = f7; imm_op = imm;
    alu_in1 = a; alu_in2 = b;
  endtask

  // Issue one request, wait (bounded) for its result and check everything.
  task automatic run_vec(input vec_t v);
    int  n;
    int  lat;
    bit  rdy_seen;
    drive(v.opc, v.f3, v.f7, v.imm, v.a, v.b);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({v.name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
    chk({v.name, "_latency"}, 64'(lat), 64'(v.lat));
    chk({v.name, "_result"}, 64'(alu_result), 64'(v.res));
    chk({v.name, "_predicate"}, 64'(predicate), 64'(v.pred));
    if (v.lat > 1) chk({v.name, "_ready_low_in_div"}, 64'(rdy_seen), 64'd0);
  endtask

  initial begin
    bit bad;

    vecs.push_back(mk("add",     OPC_ALU, FUNCT3_ADD, 0, 0, 32'd5, 32'd7, 32'd12, 0, 1));
    vecs.push_back(mk("sub",     OPC_ALU, FUNCT3_ADD, 1, 0, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 1));
    vecs.push_back(mk("addi_f7", OPC_ALU, FUNCT3_ADD, 1, 1, 32'd5, 32'd7, 32'd12, 0, 1));
    vecs.push_back(mk("sra",     OPC_ALU, FUNCT3_SR, 1, 0, 32'h80000000, 32'h24, 32'hF8000000, 0, 1));
    vecs.push_back(mk("srl",     OPC_ALU, FUNCT3_SR, 0, 0, 32'h80000000, 32'h24, 32'h08000000, 0, 1));
    vecs.push_back(mk("sll",     OPC_ALU, FUNCT3_SLL, 0, 0, 32'd1, 32'h21, 32'd2, 0, 1));
    vecs.push_back(mk("slt",     OPC_ALU, FUNCT3_SLT, 0, 0, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 1));
    vecs.push_back(mk("sltu",    OPC_ALU, FUNCT3_SLTU, 0, 0, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 1));
    vecs.push_back(mk("xor",     OPC_ALU, FUNCT3_XOR, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 1));
    vecs.push_back(mk("blt",     OPC_BRANCH, FUNCT3_BLT, 0, 0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 1, 1));
    vecs.push_back(mk("bltu",    OPC_BRANCH, FUNCT3_BLTU, 0, 0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 0, 1));
    vecs.push_back(mk("bge",     OPC_BRANCH, FUNCT3_BGE, 0, 0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 0, 1));
    vecs.push_back(mk("beq",     OPC_BRANCH, FUNCT3_BEQ, 0, 0, 32'd3, 32'd3, 32'd0, 1, 1));
    vecs.push_back(mk("br_010",  OPC_BRANCH, 3'b010, 0, 0, 32'd3, 32'd3, 32'd0, 0, 1));
    vecs.push_back(mk("addr",    OPC_ADDR, 3'b010, 0, 0, 32'h1000, 32'hFFFFFFFC, 32'h00000FFC, 0, 1));
    vecs.push_back(mk("mul",     OPC_MD, FUNCT3_MUL, 0, 0, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 0, 1));
    vecs.push_back(mk("mulh",    OPC_MD, FUNCT3_MULH, 0, 0, 32'h80000000, 32'h80000000, 32'h40000000, 0, 1));
    vecs.push_back(mk("mulhu",   OPC_MD, FUNCT3_MULHU, 0, 0, 32'h80000000, 32'h80000000, 32'h40000000, 0, 1));
    vecs.push_back(mk("mulhsu",  OPC_MD, FUNCT3_MULHSU, 0, 0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 0, 1));
    vecs.push_back(mk("div_m7_2", OPC_MD, FUNCT3_DIV, 0, 0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0, 34));
    vecs.push_back(mk("rem_m7_2", OPC_MD, FUNCT3_REM, 0, 0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0, 34));
    vecs.push_back(mk("div_7_m2", OPC_MD, FUNCT3_DIV, 0, 0, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 0, 34));
    vecs.push_back(mk("rem_7_m2", OPC_MD, FUNCT3_REM, 0, 0, 32'd7, 32'hFFFFFFFE, 32'd1, 0, 34));
    vecs.push_back(mk("divu",    OPC_MD, FUNCT3_DIVU, 0, 0, 32'd100, 32'd7, 32'd14, 0, 34));
    vecs.push_back(mk("remu",    OPC_MD, FUNCT3_REMU, 0, 0, 32'd100, 32'd7, 32'd2, 0, 34));
    vecs.push_back(mk("div_by0", OPC_MD, FUNCT3_DIV, 0, 0, 32'h1234, 32'd0, 32'hFFFFFFFF, 0, 1));
    vecs.push_back(mk("rem_by0", OPC_MD, FUNCT3_REM, 0, 0, 32'h1234, 32'd0, 32'h1234, 0, 1));
    vecs.push_back(mk("div_ovf", OPC_MD, FUNCT3_DIV, 0, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1));
    vecs.push_back(mk("rem_ovf", OPC_MD, FUNCT3_REM, 0, 0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, 1));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready_low", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(alu_result), 64'd0);
    chk("rst_predicate", 64'(predicate), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back ADD then SUB with out_ready held high.
    drive(OPC_ALU, FUNCT3_ADD, 1'b0, 1'b0, 32'd5, 32'd7);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_add_valid", 64'(out_valid), 64'd1);
    chk("b2b_add_result", 64'(alu_result), 64'd12);
    chk("b2b_sub_ready", 64'(in_ready), 64'd1);
    drive(OPC_ALU, FUNCT3_ADD, 1'b1, 1'b0, 32'd5, 32'd7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_sub_valid", 64'(out_valid), 64'd1);
    chk("b2b_sub_result", 64'(alu_result), 64'hFFFFFFFE);
    @(posedge clk); #1;
    chk("b2b_drained", 64'(out_valid), 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Output stall: result and predicate hold, no new request accepted.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(OPC_BRANCH, FUNCT3_BEQ, 1'b0, 1'b0, 32'd9, 32'd9);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("stall_valid0", 64'(out_valid), 64'd1);
    drive(OPC_ALU, FUNCT3_ADD, 1'b0, 1'b0, 32'd1, 32'd2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_result", 64'(alu_result), 64'd0);
      chk("stall_predicate", 64'(predicate), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stall_next_result", 64'(alu_result), 64'd3);
    chk("stall_next_predicate", 64'(predicate), 64'd0);
    @(posedge clk); #1;
    chk("stall_drained", 64'(out_valid), 64'd0);

    // Reset in the middle of a divide.
    drive(OPC_MD, FUNCT3_DIVU, 1'b0, 1'b0, 32'd100, 32'd7);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_div_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) bad = 1'b1;
    end
    chk("abort_no_output", 64'(bad), 64'd0);
    chk("abort_result_cleared", 64'(alu_result), 64'd0);

    // The divider must be usable again after the abort.
    run_vec(mk("post_rst_remu", OPC_MD, FUNCT3_REMU, 0, 0, 32'd100, 32'd7, 32'd2, 0, 34));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
